// File: rtl/udp_pixel_unpack_pkg.sv
// ---------------------------------------------------------------------------
// udp_pixel_unpack_pkg
// Shared definitions for the UDP payload -> RGB565 pixel unpacker:
//   - default frame geometry and packet header magic words
//   - FRAME_PIXELS and the width of the per-frame pixel counter
//   - FSM state encodings (HUNT / PIX / FILL)
// ---------------------------------------------------------------------------
package udp_pixel_unpack_pkg;

   localparam int          H_PIXELS_DEF   = 800;
   localparam int          V_LINES_DEF    = 480;
   localparam logic [31:0] SOF_MAGIC_DEF  = 32'hF05A_A50F;
   localparam logic [31:0] CONT_MAGIC_DEF = 32'hF05A_A50E;

   localparam int FRAME_PIXELS = H_PIXELS_DEF * V_LINES_DEF;

   // Width of a counter that runs 0..n-1 (at least one bit).
   function automatic int pcnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PCNT_W = pcnt_width(FRAME_PIXELS);

   // FSM state encodings
   localparam logic [1:0] ST_HUNT = 2'd0;   // waiting for a start-of-frame packet
   localparam logic [1:0] ST_PIX  = 2'd1;   // unpacking payload into pixels
   localparam logic [1:0] ST_FILL = 2'd2;   // padding the rest of a broken frame

endpackage

// File: rtl/udp_hdr_match.sv
// ---------------------------------------------------------------------------
// udp_hdr_match
// Tracks the byte position inside the current packet and recognises the
// 4-byte (MSB first) packet header.
// Ports:
//   gmii_rx_clk, sys_rst_n  clock / asynchronous active-low reset
//   rec_en, rec_data        payload byte stream
//   rec_pkt_done            end-of-packet pulse (clears the byte index)
//   hdr_done                high in the cycle of header byte 3
//   is_sof / is_cont        header equals SOF / continuation magic (qualified by hdr_done)
//   payload_en              high for every byte after the header
// ---------------------------------------------------------------------------
module udp_hdr_match
   import udp_pixel_unpack_pkg::*;
#(
   parameter logic [31:0] SOF_MAGIC  = SOF_MAGIC_DEF,
   parameter logic [31:0] CONT_MAGIC = CONT_MAGIC_DEF
) (
   input  logic       gmii_rx_clk,
   input  logic       sys_rst_n,
   input  logic       rec_en,
   input  logic [7:0] rec_data,
   input  logic       rec_pkt_done,
   output logic       hdr_done,
   output logic       is_sof,
   output logic       is_cont,
   output logic       payload_en
);

   logic [2:0]  bidx_reg;   // saturates at 4 = "in payload"
   logic [23:0] hdr_reg;    // header bytes 0..2
   logic [31:0] hdr_word;

   // The decision uses byte 3 straight off the bus, so it is available in
   // the same cycle as byte 3's rec_en.
   assign hdr_word   = {hdr_reg, rec_data};
   assign hdr_done   = rec_en && (bidx_reg == 3'd3);
   assign is_sof     = hdr_done && (hdr_word == SOF_MAGIC);
   assign is_cont    = hdr_done && (hdr_word == CONT_MAGIC);
   assign payload_en = rec_en && (bidx_reg == 3'd4);

   always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bidx_reg <= 3'd0;
         hdr_reg  <= 24'd0;
      end else begin
         if (rec_en && (bidx_reg != 3'd4)) begin
            bidx_reg <= bidx_reg + 3'd1;
            hdr_reg  <= {hdr_reg[15:0], rec_data};
         end
         // A byte arriving together with the done pulse is handled above
         // first; the index then restarts for the next packet.
         if (rec_pkt_done) begin
            bidx_reg <= 3'd0;
         end
      end
   end

endmodule

// File: rtl/udp_pixel_unpack.sv
// ---------------------------------------------------------------------------
// udp_pixel_unpack
// Frames UDP payload bytes into RGB565 pixels and guarantees exactly
// H_PIXELS*V_LINES valid pulses per frame (broken frames are padded black).
// Ports:
//   gmii_rx_clk, sys_rst_n  clock / asynchronous active-low reset
//   rec_en, rec_data        payload byte stream (at most one byte per cycle)
//   rec_pkt_done            one-cycle pulse ending a packet
//   picture_data_vld0       registered pixel valid
//   picture_data            registered RGB565 pixel
//   frame_start             with pixel 0 of each frame
//   frame_err               one-cycle error pulse
// ---------------------------------------------------------------------------
module udp_pixel_unpack
   import udp_pixel_unpack_pkg::*;
#(
   parameter int          H_PIXELS   = H_PIXELS_DEF,
   parameter int          V_LINES    = V_LINES_DEF,
   parameter logic [31:0] SOF_MAGIC  = SOF_MAGIC_DEF,
   parameter logic [31:0] CONT_MAGIC = CONT_MAGIC_DEF
) (
   input  logic        gmii_rx_clk,
   input  logic        sys_rst_n,
   input  logic        rec_en,
   input  logic [7:0]  rec_data,
   input  logic        rec_pkt_done,
   output logic        picture_data_vld0,
   output logic [15:0] picture_data,
   output logic        frame_start,
   output logic        frame_err
);

   localparam int            N    = H_PIXELS * V_LINES;
   localparam int            PW   = pcnt_width(N);
   localparam logic [PW-1:0] LAST = PW'(N - 1);

   logic hdr_done;
   logic is_sof;
   logic is_cont;
   logic payload_en;

   udp_hdr_match #(
      .SOF_MAGIC  (SOF_MAGIC),
      .CONT_MAGIC (CONT_MAGIC)
   ) u_hdr_match (
      .gmii_rx_clk  (gmii_rx_clk),
      .sys_rst_n    (sys_rst_n),
      .rec_en       (rec_en),
      .rec_data     (rec_data),
      .rec_pkt_done (rec_pkt_done),
      .hdr_done     (hdr_done),
      .is_sof       (is_sof),
      .is_cont      (is_cont),
      .payload_en   (payload_en)
   );

   logic [1:0]    state_reg, state_next;
   logic [PW-1:0] pcnt_reg,  pcnt_next;
   logic [7:0]    hi_reg,    hi_next;     // high byte waiting for its partner
   logic          half_reg,  half_next;   // hi_reg holds a pending byte
   logic          vld_reg,   vld_next;
   logic [15:0]   data_reg,  data_next;
   logic          start_reg, start_next;
   logic          err_reg,   err_next;

   always_comb begin
      state_next = state_reg;
      pcnt_next  = pcnt_reg;
      hi_next    = hi_reg;
      half_next  = half_reg;
      vld_next   = 1'b0;
      data_next  = data_reg;
      start_next = 1'b0;
      err_next   = 1'b0;

      case (state_reg)
         ST_HUNT: begin
            half_next = 1'b0;
            if (hdr_done) begin
               if (is_sof) begin
                  state_next = ST_PIX;
                  pcnt_next  = '0;
               end else if (!is_cont) begin
                  // Stray continuation packets of an aborted frame are
                  // dropped quietly; only unknown headers are errors.
                  err_next = 1'b1;
               end
            end
         end

         ST_PIX: begin
            if (hdr_done) begin
               // Anything but a continuation (early SOF or junk) aborts
               // the frame; FILL pads it out from the current pcnt.
               if (!is_cont) begin
                  err_next   = 1'b1;
                  state_next = ST_FILL;
               end
            end else if (payload_en) begin
               if (!half_reg) begin
                  hi_next   = rec_data;
                  half_next = 1'b1;
               end else begin
                  vld_next   = 1'b1;
                  data_next  = {hi_reg, rec_data};
                  start_next = (pcnt_reg == '0);
                  half_next  = 1'b0;
                  if (pcnt_reg == LAST) begin
                     // Frame complete: rest of this packet falls into HUNT.
                     state_next = ST_HUNT;
                     pcnt_next  = '0;
                  end else begin
                     pcnt_next = pcnt_reg + PW'(1);
                  end
               end
            end
            // Packet end with an unpaired byte (after this cycle's byte is
            // taken into account): drop it, flag it, carry nothing over.
            if (rec_pkt_done && (state_next == ST_PIX)) begin
               if (half_next) begin
                  err_next = 1'b1;
               end
               half_next = 1'b0;
            end
         end

         ST_FILL: begin
            half_next = 1'b0;
            vld_next  = 1'b1;
            data_next = 16'd0;
            if (pcnt_reg == LAST) begin
               state_next = ST_HUNT;
               pcnt_next  = '0;
            end else begin
               pcnt_next = pcnt_reg + PW'(1);
            end
         end

         default: begin
            state_next = ST_HUNT;
            pcnt_next  = '0;
            half_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg <= ST_HUNT;
         pcnt_reg  <= '0;
         hi_reg    <= 8'd0;
         half_reg  <= 1'b0;
         vld_reg   <= 1'b0;
         data_reg  <= 16'd0;
         start_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         pcnt_reg  <= pcnt_next;
         hi_reg    <= hi_next;
         half_reg  <= half_next;
         vld_reg   <= vld_next;
         data_reg  <= data_next;
         start_reg <= start_next;
         err_reg   <= err_next;
      end
   end

   assign picture_data_vld0 = vld_reg;
   assign picture_data      = data_reg;
   assign frame_start       = start_reg;
   assign frame_err         = err_reg;

endmodule

// File: tb/tb_udp_pixel_unpack.sv
// ---------------------------------------------------------------------------
// tb_udp_pixel_unpack
// Randomised packet stimulus against a packet-level reference model of the
// unpacker (expected pixel stream, frame_start flags and error count).
// A small frame geometry keeps runs short.
// ---------------------------------------------------------------------------
module tb_udp_pixel_unpack;

   localparam int          H    = 16;
   localparam int          V    = 8;
   localparam int          N    = H * V;
   localparam logic [31:0] SOF  = 32'hF05A_A50F;
   localparam logic [31:0] CONT = 32'hF05A_A50E;

   logic        gmii_rx_clk = 1'b0;
   logic        sys_rst_n   = 1'b1;
   logic        rec_en      = 1'b0;
   logic [7:0]  rec_data    = 8'd0;
   logic        rec_pkt_done = 1'b0;
   logic        picture_data_vld0;
   logic [15:0] picture_data;
   logic        frame_start;
   logic        frame_err;

   udp_pixel_unpack #(
      .H_PIXELS   (H),
      .V_LINES    (V),
      .SOF_MAGIC  (SOF),
      .CONT_MAGIC (CONT)
   ) dut (
      .gmii_rx_clk       (gmii_rx_clk),
      .sys_rst_n         (sys_rst_n),
      .rec_en            (rec_en),
      .rec_data          (rec_data),
      .rec_pkt_done      (rec_pkt_done),
      .picture_data_vld0 (picture_data_vld0),
      .picture_data      (picture_data),
      .frame_start       (frame_start),
      .frame_err         (frame_err)
   );

   always #4 gmii_rx_clk = ~gmii_rx_clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // observed stream (monitor)
   int unsigned cyc = 0;
   logic [15:0] obs_data[$];
   logic        obs_start[$];
   int unsigned obs_cyc[$];
   int          obs_err = 0;

   // expected stream (model)
   logic [15:0] exp_data[$];
   logic        exp_start[$];
   int          exp_err = 0;
   bit          m_in_frame = 1'b0;
   int          m_cnt = 0;

   logic [7:0]  pkt[$];

   always @(negedge gmii_rx_clk) begin
      cyc++;
      if (sys_rst_n) begin
         if (picture_data_vld0) begin
            obs_data.push_back(picture_data);
            obs_start.push_back(frame_start);
            obs_cyc.push_back(cyc);
         end
         if (frame_err) obs_err++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: consumes one whole packet (pkt) and appends what the
   // unpacker must emit for it.
   task automatic model_pkt();
      logic [31:0] hdr;
      int i;
      if (pkt.size() < 4) return;
      hdr = {pkt[0], pkt[1], pkt[2], pkt[3]};
      if (!m_in_frame) begin
         if (hdr == SOF) begin
            m_in_frame = 1'b1;
            m_cnt      = 0;
         end else begin
            if (hdr != CONT) exp_err++;
            return;
         end
      end else if (hdr != CONT) begin
         exp_err++;
         while (m_cnt < N) begin
            exp_data.push_back(16'd0);
            exp_start.push_back(1'b0);
            m_cnt++;
         end
         m_in_frame = 1'b0;
         return;
      end
      i = 4;
      while (m_in_frame && (i + 1 < pkt.size())) begin
         exp_data.push_back({pkt[i], pkt[i+1]});
         exp_start.push_back(m_cnt == 0);
         m_cnt++;
         i += 2;
         if (m_cnt == N) m_in_frame = 1'b0;
      end
      if (m_in_frame && (i < pkt.size())) exp_err++;
   endtask

   task automatic tick();
      @(posedge gmii_rx_clk);
      #1;
   endtask

   task automatic send_pkt(input bit done_sep);
      for (int i = 0; i < pkt.size(); i++) begin
         rec_en       = 1'b1;
         rec_data     = pkt[i];
         rec_pkt_done = !done_sep && (i == pkt.size() - 1);
         tick();
         rec_en       = 1'b0;
         rec_pkt_done = 1'b0;
         if ($urandom_range(0, 3) == 0) tick();
      end
      if (done_sep || pkt.size() == 0) begin
         rec_pkt_done = 1'b1;
         tick();
         rec_pkt_done = 1'b0;
      end
   endtask

   // Let the DUT catch up (including any padding) before the next packet.
   task automatic sync();
      int t = 0;
      while ((obs_data.size() < exp_data.size()) && (t < 2 * N + 50)) begin
         tick();
         t++;
      end
      if (obs_data.size() < exp_data.size())
         check("sync_timeout", obs_data.size(), exp_data.size());
      repeat (2) tick();
   endtask

   task automatic do_pkt();
      model_pkt();
      send_pkt(1'($urandom_range(0, 1)));
      sync();
   endtask

   task automatic mk_hdr(input logic [31:0] h);
      pkt.delete();
      pkt.push_back(h[31:24]);
      pkt.push_back(h[23:16]);
      pkt.push_back(h[15:8]);
      pkt.push_back(h[7:0]);
   endtask

   task automatic add_pix(input logic [15:0] v);
      pkt.push_back(v[15:8]);
      pkt.push_back(v[7:0]);
   endtask

   // Continuation packets (with the odd runt) until the model says the
   // frame is complete; extra bytes ride on the final packet.
   task automatic finish_frame(input bit seq, input int extra);
      int k;
      while (m_in_frame) begin
         if ($urandom_range(0, 4) == 0) begin
            pkt.delete();
            repeat ($urandom_range(0, 3)) pkt.push_back(8'($urandom));
            do_pkt();
         end
         mk_hdr(CONT);
         k = $urandom_range(1, 20);
         if (k > N - m_cnt) k = N - m_cnt;
         for (int j = 0; j < k; j++) add_pix(seq ? 16'(m_cnt + j) : 16'($urandom));
         if (k == N - m_cnt) repeat (extra) pkt.push_back(8'($urandom));
         do_pkt();
      end
   endtask

   task automatic send_frame(input bit seq, input int extra);
      int k;
      mk_hdr(SOF);
      k = $urandom_range(0, 20);
      for (int j = 0; j < k; j++) add_pix(seq ? 16'(j) : 16'($urandom));
      do_pkt();
      finish_frame(seq, extra);
   endtask

   task automatic clear_all();
      obs_data.delete(); obs_start.delete(); obs_cyc.delete();
      exp_data.delete(); exp_start.delete();
      obs_err = 0;
      exp_err = 0;
   endtask

   task automatic compare(input string tag);
      int f0;
      repeat (5) tick();
      check({tag, "_count"}, obs_data.size(), exp_data.size());
      for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
         f0 = tests_failed;
         check($sformatf("%s_data[%0d]", tag, i), obs_data[i], exp_data[i]);
         check($sformatf("%s_start[%0d]", tag, i), obs_start[i], exp_start[i]);
         if (tests_failed != f0) break;
      end
      check({tag, "_errs"}, obs_err, exp_err);
      $display("[TB] %s: %0d pixels, %0d errors", tag, obs_data.size(), obs_err);
      clear_all();
   endtask

   initial begin
      int first;
      int k;
      #1 sys_rst_n = 1'b0;
      repeat (3) tick();
      check("rst_vld",   picture_data_vld0, 1'b0);
      check("rst_data",  picture_data, 16'd0);
      check("rst_start", frame_start, 1'b0);
      check("rst_err",   frame_err, 1'b0);
      sys_rst_n = 1'b1;
      repeat (2) tick();

      // clean frame, pixel i = i
      send_frame(1'b1, 0);
      compare("clean");

      // garbage header, then a good frame
      mk_hdr(32'h1234_5678);
      repeat (10) pkt.push_back(8'($urandom));
      do_pkt();
      send_frame(1'b0, 0);
      compare("garbage");

      // early SOF after 10 pixels -> padding, then a fresh frame
      mk_hdr(SOF);
      for (int j = 0; j < 10; j++) add_pix(16'($urandom));
      do_pkt();
      mk_hdr(SOF);
      repeat (6) pkt.push_back(8'($urandom));
      do_pkt();
      check("fill_size", obs_data.size(), N);
      if (obs_data.size() >= N) begin
         first = obs_data.size() - (N - 10);
         check("fill_contig", obs_cyc[obs_data.size() - 1] - obs_cyc[first], N - 11);
      end
      send_frame(1'b0, 0);
      compare("early_sof");

      // odd-length continuation packet
      mk_hdr(SOF);
      for (int j = 0; j < 4; j++) add_pix(16'($urandom));
      do_pkt();
      mk_hdr(CONT);
      repeat (7) pkt.push_back(8'($urandom));
      do_pkt();
      finish_frame(1'b0, 0);
      compare("odd_len");

      // overrun on the last packet, then runts while hunting
      send_frame(1'b0, 10);
      pkt.delete();
      pkt.push_back(8'hF0);
      pkt.push_back(8'h5A);
      do_pkt();
      compare("overrun");

      // random packet mix
      for (int p = 0; p < 40; p++) begin
         k = $urandom_range(0, 9);
         if (k < 1) begin
            pkt.delete();
            repeat ($urandom_range(0, 3)) pkt.push_back(8'($urandom));
         end else begin
            if (k < 4)      mk_hdr(SOF);
            else if (k < 9) mk_hdr(CONT);
            else            mk_hdr($urandom);
            repeat ($urandom_range(0, 41)) pkt.push_back(8'($urandom));
         end
         do_pkt();
      end
      if (m_in_frame) finish_frame(1'b0, 0);
      compare("random");

      // reset in the middle of a frame, right as pixel 40 is presented
      mk_hdr(SOF);
      for (int j = 0; j < 60; j++) add_pix(16'hA500 | 16'(j));
      for (int i = 0; i < pkt.size(); i++) begin
         rec_en   = 1'b1;
         rec_data = pkt[i];
         tick();
         if (i == 4 + 2 * 40 + 1) break;
      end
      rec_en = 1'b0;
      check("pre_rst_vld", picture_data_vld0, 1'b1);
      sys_rst_n = 1'b0;
      #1;
      check("midrst_vld",   picture_data_vld0, 1'b0);
      check("midrst_data",  picture_data, 16'd0);
      check("midrst_start", frame_start, 1'b0);
      check("midrst_err",   frame_err, 1'b0);
      m_in_frame = 1'b0;
      m_cnt      = 0;
      repeat (3) tick();
      clear_all();
      sys_rst_n = 1'b1;
      repeat (2) tick();
      send_frame(1'b1, 0);
      compare("post_reset");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
